// File: rtl/clock_set_core.sv
// Time-of-day core: HH:MM:SS counters, alarm, field-by-field setting.
// Ports: sysclk/rst, key pulses in; six BCD digits, twinkle, pm,
// valid_sd, alarm_en, alarm_ring out (all registered).
module clock_set_core #(
    parameter int CLK_DIV     = 50000000,
    parameter int TWINKLE_DIV = 12500000,
    parameter int HOUR_24     = 1,
    parameter int RING_SEC    = 60
) (
    input  logic       sysclk,
    input  logic       rst,
    input  logic       long_pression1,
    input  logic       short_pression1,
    input  logic       long_pression0,
    input  logic       short_pression0,
    output logic [3:0] reg_num6,
    output logic [3:0] reg_num5,
    output logic [3:0] reg_num4,
    output logic [3:0] reg_num3,
    output logic [3:0] reg_num2,
    output logic [3:0] reg_num1,
    output logic [5:0] twinkle,
    output logic       pm,
    output logic       valid_sd,
    output logic       alarm_en,
    output logic       alarm_ring
);

    localparam int PW = $clog2(CLK_DIV);
    localparam int BW = (TWINKLE_DIV > 1) ? $clog2(TWINKLE_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX   = PW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(TWINKLE_DIV - 1);
    localparam logic [7:0]    RING_LOAD = 8'(RING_SEC);
    localparam logic [3:0]    RST_HT = (HOUR_24 != 0) ? 4'd0 : 4'd1;
    localparam logic [3:0]    RST_HU = (HOUR_24 != 0) ? 4'd0 : 4'd2;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        SET_TIME  = 2'd1,
        SET_ALARM = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [PW-1:0] prescaler;
    logic [4:0]    hour;
    logic [5:0]    min;
    logic [5:0]    sec;
    logic [4:0]    alm_hour;
    logic [5:0]    alm_min;
    logic [1:0]    field;
    logic          phase;
    logic [BW-1:0] blink_cnt;
    logic [7:0]    ring_cnt;

    // Binary 0..59 to two BCD digits.
    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        logic [5:0] r;
        logic [3:0] t;
        r = v;
        t = 4'd0;
        if (r >= 6'd40) begin
            r = r - 6'd40;
            t = t + 4'd4;
        end
        if (r >= 6'd20) begin
            r = r - 6'd20;
            t = t + 4'd2;
        end
        if (r >= 6'd10) begin
            r = r - 6'd10;
            t = t + 4'd1;
        end
        return {t, 4'(r)};
    endfunction

    // Only the highest-priority pulse of a cycle acts.
    logic p_l1, p_l0, p_s1, p_s0;
    always_comb begin
        p_l1 = long_pression1;
        p_l0 = long_pression0 & ~long_pression1;
        p_s1 = short_pression1 & ~long_pression1 & ~long_pression0;
        p_s0 = short_pression0 & ~long_pression1 & ~long_pression0
             & ~short_pression1;
    end

    // FSM: state register
    always_ff @(posedge sysclk) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            RUN: begin
                if (p_l1)      state_nxt = SET_TIME;
                else if (p_l0) state_nxt = SET_ALARM;
            end
            SET_TIME: begin
                if (p_l1) state_nxt = RUN;
            end
            SET_ALARM: begin
                if (p_l0) state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    // FSM: control outputs
    logic in_set, counting, tick;
    logic edit_time, edit_alarm, adv_field;
    logic toggle_alarm, enter_set, restart_blink;
    always_comb begin
        in_set        = (state != RUN);
        counting      = (state != SET_TIME);
        tick          = counting && (prescaler == PRE_MAX);
        edit_time     = (state == SET_TIME) && p_s0;
        edit_alarm    = (state == SET_ALARM) && p_s0;
        adv_field     = in_set && p_s1;
        toggle_alarm  = (state == RUN) && p_s0;
        enter_set     = (state == RUN) && (state_nxt != RUN);
        restart_blink = enter_set || adv_field;
    end

    // Held at 0 throughout SET_TIME, so leaving it restarts a full second.
    always_ff @(posedge sysclk) begin
        if (rst || !counting) prescaler <= '0;
        else if (tick)        prescaler <= '0;
        else                  prescaler <= prescaler + PW'(1);
    end

    // Incremented values, shared by carry chain and field editing.
    logic       sec_wrap, min_wrap, hour_wrap;
    logic [5:0] sec_n, min_n, alm_min_n;
    logic [4:0] hour_n, alm_hour_n;
    always_comb begin
        sec_wrap   = (sec == 6'd59);
        min_wrap   = (min == 6'd59);
        hour_wrap  = (hour == 5'd23);
        sec_n      = sec_wrap ? 6'd0 : sec + 6'd1;
        min_n      = min_wrap ? 6'd0 : min + 6'd1;
        hour_n     = hour_wrap ? 5'd0 : hour + 5'd1;
        alm_min_n  = (alm_min == 6'd59) ? 6'd0 : alm_min + 6'd1;
        alm_hour_n = (alm_hour == 5'd23) ? 5'd0 : alm_hour + 5'd1;
    end

    // Ticks never occur in SET_TIME, so they cannot collide with edits.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            hour <= 5'd0;
            min  <= 6'd0;
            sec  <= 6'd0;
        end else if (tick) begin
            sec <= sec_n;
            if (sec_wrap) begin
                min <= min_n;
                if (min_wrap) hour <= hour_n;
            end
        end else if (edit_time) begin
            case (field)
                2'd0:    hour <= hour_n;
                2'd1:    min  <= min_n;
                2'd2:    sec  <= sec_n;
                default: ;
            endcase
        end
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            alm_hour <= 5'd0;
            alm_min  <= 6'd0;
        end else if (edit_alarm) begin
            if (field == 2'd0) alm_hour <= alm_hour_n;
            else               alm_min  <= alm_min_n;
        end
    end

    always_ff @(posedge sysclk) begin
        if (rst || enter_set) begin
            field <= 2'd0;
        end else if (adv_field) begin
            if (state == SET_TIME)
                field <= (field == 2'd2) ? 2'd0 : field + 2'd1;
            else
                field <= (field == 2'd1) ? 2'd0 : field + 2'd1;
        end
    end

    // Phase "on" is encoded as 0: the selected digits strobe first.
    always_ff @(posedge sysclk) begin
        if (rst || restart_blink) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (blink_cnt == BLINK_MAX) begin
            blink_cnt <= '0;
            phase     <= ~phase;
        end else begin
            blink_cnt <= blink_cnt + BW'(1);
        end
    end

    // Match against the time this tick is about to produce.
    logic [5:0] t_min;
    logic [4:0] t_hour;
    logic       match;
    always_comb begin
        t_min  = sec_wrap ? min_n : min;
        t_hour = (sec_wrap && min_wrap) ? hour_n : hour;
        match  = tick && sec_wrap && (t_min == alm_min)
              && (t_hour == alm_hour);
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            alarm_en   <= 1'b0;
            alarm_ring <= 1'b0;
            ring_cnt   <= 8'd0;
        end else if (toggle_alarm) begin
            alarm_en   <= ~alarm_en;
            alarm_ring <= 1'b0;
            ring_cnt   <= 8'd0;
        end else if (match && alarm_en) begin
            alarm_ring <= 1'b1;
            ring_cnt   <= RING_LOAD;
        end else if (tick && alarm_ring) begin
            ring_cnt <= ring_cnt - 8'd1;
            if (ring_cnt <= 8'd1) alarm_ring <= 1'b0;
        end
    end

    // Display path: source select, 12 h mapping, BCD, blink mask.
    logic [4:0] d_hour, h_shown;
    logic [5:0] d_min, d_sec;
    logic [7:0] hb, mb, sb;
    logic       pm_n;
    logic [5:0] twinkle_n;
    always_comb begin
        if (state == SET_ALARM) begin
            d_hour = alm_hour;
            d_min  = alm_min;
            d_sec  = 6'd0;
        end else begin
            d_hour = hour;
            d_min  = min;
            d_sec  = sec;
        end
        if (HOUR_24 != 0) begin
            h_shown = d_hour;
            pm_n    = 1'b0;
        end else begin
            if (d_hour == 5'd0)      h_shown = 5'd12;
            else if (d_hour > 5'd12) h_shown = d_hour - 5'd12;
            else                     h_shown = d_hour;
            pm_n = (d_hour >= 5'd12);
        end
        hb = to_bcd({1'b0, h_shown});
        mb = to_bcd(d_min);
        sb = to_bcd(d_sec);
        twinkle_n = 6'b000000;
        if (in_set) begin
            case (field)
                2'd0:    twinkle_n = {{2{~phase}}, 4'b0000};
                2'd1:    twinkle_n = {2'b00, {2{~phase}}, 2'b00};
                2'd2:    twinkle_n = {4'b0000, {2{~phase}}};
                default: twinkle_n = 6'b000000;
            endcase
        end
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            reg_num6 <= RST_HT;
            reg_num5 <= RST_HU;
            reg_num4 <= 4'd0;
            reg_num3 <= 4'd0;
            reg_num2 <= 4'd0;
            reg_num1 <= 4'd0;
            twinkle  <= 6'b000000;
            pm       <= 1'b0;
            valid_sd <= 1'b1;
        end else begin
            reg_num6 <= hb[7:4];
            reg_num5 <= hb[3:0];
            reg_num4 <= mb[7:4];
            reg_num3 <= mb[3:0];
            reg_num2 <= sb[7:4];
            reg_num1 <= sb[3:0];
            twinkle  <= twinkle_n;
            pm       <= pm_n;
            valid_sd <= (state == RUN);
        end
    end

endmodule

// File: tb/tb_clock_set_core.sv
// Directed bench for clock_set_core: 24 h and 12 h instances share stimulus.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_clock_set_core;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic long_pression1 = 1'b0;
    logic short_pression1 = 1'b0;
    logic long_pression0 = 1'b0;
    logic short_pression0 = 1'b0;

    logic [3:0] a6, a5, a4, a3, a2, a1;
    logic [3:0] b6, b5, b4, b3, b2, b1;
    logic [5:0] tw24, tw12;
    logic pm24, pm12, vs24, vs12, en24, en12, rg24, rg12;
    logic [23:0] dig24, dig12;

    assign dig24 = {a6, a5, a4, a3, a2, a1};
    assign dig12 = {b6, b5, b4, b3, b2, b1};

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    clock_set_core #(
        .CLK_DIV(4), .TWINKLE_DIV(2), .HOUR_24(1), .RING_SEC(3)
    ) u_dut24 (
        .sysclk(clk), .rst(rst),
        .long_pression1(long_pression1), .short_pression1(short_pression1),
        .long_pression0(long_pression0), .short_pression0(short_pression0),
        .reg_num6(a6), .reg_num5(a5), .reg_num4(a4),
        .reg_num3(a3), .reg_num2(a2), .reg_num1(a1),
        .twinkle(tw24), .pm(pm24), .valid_sd(vs24),
        .alarm_en(en24), .alarm_ring(rg24)
    );

    clock_set_core #(
        .CLK_DIV(4), .TWINKLE_DIV(2), .HOUR_24(0), .RING_SEC(3)
    ) u_dut12 (
        .sysclk(clk), .rst(rst),
        .long_pression1(long_pression1), .short_pression1(short_pression1),
        .long_pression0(long_pression0), .short_pression0(short_pression0),
        .reg_num6(b6), .reg_num5(b5), .reg_num4(b4),
        .reg_num3(b3), .reg_num2(b2), .reg_num1(b1),
        .twinkle(tw12), .pm(pm12), .valid_sd(vs12),
        .alarm_en(en12), .alarm_ring(rg12)
    );

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // 0=short0 1=short1 2=long0 3=long1; acts on the next rising edge.
    task automatic press(input int which);
        case (which)
            0:       short_pression0 = 1'b1;
            1:       short_pression1 = 1'b1;
            2:       long_pression0 = 1'b1;
            default: long_pression1 = 1'b1;
        endcase
        cyc(1);
        short_pression0 = 1'b0;
        short_pression1 = 1'b0;
        long_pression0 = 1'b0;
        long_pression1 = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if (dig24 !== 24'h000000) begin
            fails++;
            $display("FAIL reset_dig24: got %h want 000000", dig24);
        end
        tests++;
        if (dig12 !== 24'h120000) begin
            fails++;
            $display("FAIL reset_dig12: got %h want 120000", dig12);
        end
        tests++;
        if ({tw24, tw12} !== 12'h000) begin
            fails++;
            $display("FAIL reset_twinkle: got %h want 000", {tw24, tw12});
        end
        tests++;
        if ({vs24, vs12, en24, en12, rg24, rg12, pm24, pm12} !== 8'b11000000)
        begin
            fails++;
            $display("FAIL reset_flags: got %b want 11000000",
                     {vs24, vs12, en24, en12, rg24, rg12, pm24, pm12});
        end
    endtask

    task automatic test_hour_carry();
        do_reset();
        cyc(14397);
        tests++;
        if (dig24 !== 24'h005959) begin
            fails++;
            $display("FAIL carry_pre: got %h want 005959", dig24);
        end
        cyc(3);
        tests++;
        if (dig24 !== 24'h005959) begin
            fails++;
            $display("FAIL carry_hold: got %h want 005959", dig24);
        end
        cyc(1);
        tests++;
        if (dig24 !== 24'h010000) begin
            fails++;
            $display("FAIL carry_hour: got %h want 010000", dig24);
        end
        tests++;
        if ({dig12, pm12} !== {24'h010000, 1'b0}) begin
            fails++;
            $display("FAIL carry_12h: got %h pm %b want 010000 pm 0",
                     dig12, pm12);
        end
    endtask

    task automatic test_set_time();
        do_reset();
        press(3);
        cyc(1);
        tests++;
        if ({vs24, tw24} !== {1'b0, 6'b110000}) begin
            fails++;
            $display("FAIL set_enter: got vs %b tw %b want vs 0 tw 110000",
                     vs24, tw24);
        end
        cyc(1);
        tests++;
        if (tw24 !== 6'b110000) begin
            fails++;
            $display("FAIL blink_on2: got %b want 110000", tw24);
        end
        cyc(1);
        tests++;
        if (tw24 !== 6'b000000) begin
            fails++;
            $display("FAIL blink_off1: got %b want 000000", tw24);
        end
        cyc(1);
        tests++;
        if (tw24 !== 6'b000000) begin
            fails++;
            $display("FAIL blink_off2: got %b want 000000", tw24);
        end
        cyc(1);
        tests++;
        if (tw24 !== 6'b110000) begin
            fails++;
            $display("FAIL blink_on3: got %b want 110000", tw24);
        end
        for (int i = 0; i < 3; i++) press(0);
        cyc(1);
        tests++;
        if (dig24 !== 24'h030000) begin
            fails++;
            $display("FAIL set_hours: got %h want 030000", dig24);
        end
        press(1);
        cyc(1);
        tests++;
        if (tw24 !== 6'b001100) begin
            fails++;
            $display("FAIL field_restart: got %b want 001100", tw24);
        end
        cyc(1);
        tests++;
        if (tw24 !== 6'b001100) begin
            fails++;
            $display("FAIL field_on2: got %b want 001100", tw24);
        end
        cyc(1);
        tests++;
        if (tw24 !== 6'b000000) begin
            fails++;
            $display("FAIL field_off: got %b want 000000", tw24);
        end
        for (int i = 0; i < 61; i++) press(0);
        press(3);
        cyc(1);
        tests++;
        if ({vs24, tw24, dig24} !== {1'b1, 6'b000000, 24'h030100}) begin
            fails++;
            $display("FAIL set_exit: got vs %b tw %b %h want 1 000000 030100",
                     vs24, tw24, dig24);
        end
        cyc(3);
        tests++;
        if (dig24 !== 24'h030100) begin
            fails++;
            $display("FAIL exit_no_tick: got %h want 030100", dig24);
        end
        cyc(1);
        tests++;
        if (dig24 !== 24'h030101) begin
            fails++;
            $display("FAIL exit_first_tick: got %h want 030101", dig24);
        end
    endtask

    task automatic test_day_wrap();
        do_reset();
        press(3);
        for (int i = 1; i <= 23; i++) begin
            press(0);
            if (i == 12 || i == 13) begin
                cyc(1);
                tests++;
                if ({b6, b5, pm12} !== {((i == 12) ? 8'h12 : 8'h01), 1'b1})
                begin
                    fails++;
                    $display("FAIL h12_hour%0d: got %h%h pm %b", i, b6, b5,
                             pm12);
                end
            end
        end
        press(1);
        for (int i = 0; i < 59; i++) press(0);
        press(1);
        for (int i = 0; i < 59; i++) press(0);
        press(3);
        cyc(1);
        tests++;
        if ({dig24, dig12, pm12} !== {24'h235959, 24'h115959, 1'b1}) begin
            fails++;
            $display("FAIL day_pre: got %h %h pm %b want 235959 115959 pm 1",
                     dig24, dig12, pm12);
        end
        cyc(3);
        tests++;
        if (dig24 !== 24'h235959) begin
            fails++;
            $display("FAIL day_hold: got %h want 235959", dig24);
        end
        cyc(1);
        tests++;
        if ({dig24, dig12, pm12} !== {24'h000000, 24'h120000, 1'b0}) begin
            fails++;
            $display("FAIL day_wrap: got %h %h pm %b want 000000 120000 pm 0",
                     dig24, dig12, pm12);
        end
    endtask

    task automatic test_alarm();
        bit seen;
        do_reset();
        press(2);
        cyc(1);
        tests++;
        if ({vs24, dig24} !== {1'b0, 24'h000000}) begin
            fails++;
            $display("FAIL alm_enter: got vs %b %h want 0 000000", vs24, dig24);
        end
        press(1);
        press(0);
        cyc(1);
        tests++;
        if ({dig24, tw24} !== {24'h000100, 6'b001100}) begin
            fails++;
            $display("FAIL alm_edit: got %h tw %b want 000100 tw 001100",
                     dig24, tw24);
        end
        press(2);
        press(0);
        tests++;
        if ({en24, rg24} !== 2'b10) begin
            fails++;
            $display("FAIL alm_arm: got en %b ring %b want 1 0", en24, rg24);
        end
        seen = 1'b0;
        for (int k = 0; k < 400 && !seen; k++) begin
            if (rg24) seen = 1'b1;
            else      cyc(1);
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL alm_ring_timeout: got ring 0 want 1");
            return;
        end
        tests++;
        if (dig24 !== 24'h000059) begin
            fails++;
            $display("FAIL alm_ring_time: got %h want 000059", dig24);
        end
        cyc(1);
        tests++;
        if (dig24 !== 24'h000100) begin
            fails++;
            $display("FAIL alm_match_time: got %h want 000100", dig24);
        end
        cyc(10);
        tests++;
        if (rg24 !== 1'b1) begin
            fails++;
            $display("FAIL alm_ring_hold: got %b want 1", rg24);
        end
        cyc(1);
        tests++;
        if (rg24 !== 1'b0) begin
            fails++;
            $display("FAIL alm_ring_drop: got %b want 0", rg24);
        end
        press(2);
        press(1);
        press(0);
        press(2);
        seen = 1'b0;
        for (int k = 0; k < 400 && !seen; k++) begin
            if (rg24) seen = 1'b1;
            else      cyc(1);
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL alm_ring2_timeout: got ring 0 want 1");
            return;
        end
        cyc(2);
        press(0);
        tests++;
        if ({en24, rg24} !== 2'b00) begin
            fails++;
            $display("FAIL alm_clear: got en %b ring %b want 0 0", en24, rg24);
        end
    endtask

    task automatic test_priority();
        do_reset();
        long_pression1 = 1'b1;
        short_pression0 = 1'b1;
        cyc(1);
        long_pression1 = 1'b0;
        short_pression0 = 1'b0;
        cyc(1);
        tests++;
        if ({vs24, en24, dig24} !== {2'b00, 24'h000000}) begin
            fails++;
            $display("FAIL prio: got vs %b en %b %h want 0 0 000000",
                     vs24, en24, dig24);
        end
        press(2);
        press(0);
        cyc(1);
        tests++;
        if ({vs24, dig24} !== {1'b0, 24'h010000}) begin
            fails++;
            $display("FAIL prio_ignore_l0: got vs %b %h want 0 010000",
                     vs24, dig24);
        end
        press(3);
    endtask

    task automatic test_reset_mid();
        do_reset();
        press(2);
        for (int i = 0; i < 5; i++) press(0);
        cyc(1);
        tests++;
        if (dig24 !== 24'h050000) begin
            fails++;
            $display("FAIL mid_edit: got %h want 050000", dig24);
        end
        do_reset();
        tests++;
        if ({dig24, dig12, tw24, vs24, en24, rg24} !==
            {24'h000000, 24'h120000, 6'b000000, 3'b100}) begin
            fails++;
            $display("FAIL mid_reset: got %h %h tw %b vs %b en %b ring %b",
                     dig24, dig12, tw24, vs24, en24, rg24);
        end
        press(2);
        cyc(1);
        tests++;
        if ({dig24, tw24} !== {24'h000000, 6'b110000}) begin
            fails++;
            $display("FAIL mid_discard: got %h tw %b want 000000 tw 110000",
                     dig24, tw24);
        end
        press(2);
    endtask

    initial begin
        test_reset();
        test_hour_carry();
        test_set_time();
        test_day_wrap();
        test_alarm();
        test_priority();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
